// File: rtl/dmem_responder_pkg.sv
// Shared opcode constants, FSM encoding and decode helpers for the data-memory responder.
package dmem_responder_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [5:0] op);
        logic [1:0] sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] lane);
        logic bad;
        case (op_size(op))
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_responder_lane_unit.sv
// Byte-lane steering: store byte enables / replicated write data, load extraction and extension.
// Purely combinational, no backpressure.
module dmem_lane_unit
    import dmem_responder_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = 8'(rword >> {lane, 3'b000});
        half_sel   = lane[1] ? rword[31:16] : rword[15:0];
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = 32'h0;

        case (op_size(op))
            SZ_BYTE: begin
                be         = 4'b0001 << lane;
                wdata_lane = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be         = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
        endcase

        case (op)
            OP_LB:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  rdata_ext = {24'h0, byte_sel};
            OP_LH:   rdata_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  rdata_ext = {16'h0, half_sel};
            OP_LW:   rdata_ext = rword;
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a load/store, stalls WAIT_CYCLES+1 cycles, then answers in DONE.
// Stall is combinational; misaligned or unknown requests are rejected in IDLE without stalling.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memen,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        adel,
    output logic        ades
);

    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [5:0]            op_q, op_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rword_q, rword_d;

    logic [31:0] ram [DEPTH];

    logic                  in_idle, req_ok, mis, accept, enter_done, ram_we;
    logic [5:0]            cur_op;
    logic [ADDR_WIDTH+1:0] cur_addr;
    logic [31:0]           cur_wdata;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [3:0]            be;
    logic [31:0]           wdata_lane, rdata_ext;
    logic                  addr_unused;

    // Upper address bits alias onto the RAM and are deliberately dropped.
    assign addr_unused = ^addr[31:ADDR_WIDTH+2];

    always_comb begin
        in_idle = (state_q == ST_IDLE);
        req_ok  = rst && memen && (is_load(op) || is_store(op));
        mis     = misaligned(op, addr[1:0]);
        accept  = in_idle && req_ok && !mis;
        adel    = in_idle && req_ok && is_load(op) && mis;
        ades    = in_idle && req_ok && is_store(op) && mis;
        stall   = accept || (state_q == ST_WAIT);
    end

    // In IDLE the live inputs drive the lane unit so WAIT_CYCLES=0 can commit on the accept edge.
    always_comb begin
        cur_op    = in_idle ? op : op_q;
        cur_addr  = in_idle ? addr[ADDR_WIDTH+1:0] : addr_q;
        cur_wdata = in_idle ? wdata : wdata_q;
        cur_idx   = cur_addr[ADDR_WIDTH+1:2];
    end

    dmem_lane_unit u_lane (
        .op         (cur_op),
        .lane       (cur_addr[1:0]),
        .wdata      (cur_wdata),
        .rword      (rword_q),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = op;
                    addr_d  = addr[ADDR_WIDTH+1:0];
                    wdata_d = wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
        ram_we     = rst && enter_done && is_store(cur_op);
        rword_d    = enter_done ? ram[cur_idx] : rword_q;
        rdata      = ((state_q == ST_DONE) && is_load(op_q)) ? rdata_ext : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 6'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rword_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rword_q <= rword_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram[cur_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: transaction-level memory model plus per-cycle output compare.
module tb_dmem_responder;

    localparam int W_A = 2;
    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
    localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        memen_a = 1'b0;
    logic [5:0]  op_a    = 6'h0;
    logic [31:0] addr_a  = 32'h0, wdata_a = 32'h0;
    logic [31:0] rdata_a;
    logic        stall_a, adel_a, ades_a;

    logic        memen_b = 1'b0;
    logic [5:0]  op_b    = 6'h0;
    logic [31:0] addr_b  = 32'h0, wdata_b = 32'h0;
    logic [31:0] rdata_b;
    logic        stall_b, adel_b, ades_b;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W_A)) dut_a (
        .clk(clk), .rst(rst), .memen(memen_a), .op(op_a), .addr(addr_a), .wdata(wdata_a),
        .rdata(rdata_a), .stall(stall_a), .adel(adel_a), .ades(ades_a)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .memen(memen_b), .op(op_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .stall(stall_b), .adel(adel_b), .ades(ades_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic        chk_en = 1'b0, lit_en = 1'b0;
    logic        exp_stall = 1'b0, exp_adel = 1'b0, exp_ades = 1'b0;
    logic [31:0] exp_rdata = 32'h0, exp_lit = 32'h0;

    logic [31:0] ref_mem [int];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'd1024);
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] o, input logic [31:0] a);
        logic [31:0] w, v;
        w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
        v = 32'h0;
        if (o == LB || o == LBU) begin
            v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
            if (o == LB && v >= 32'd128) v = v | 32'hFFFFFF00;
        end else if (o == LH || o == LHU) begin
            v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
            if (o == LH && v >= 32'd32768) v = v | 32'hFFFF0000;
        end else if (o == LW) begin
            v = w;
        end
        return v;
    endfunction

    function automatic void model_store(input logic [5:0] o, input logic [31:0] a,
                                        input logic [31:0] wd);
        logic [31:0] w;
        w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] nb;
            logic       hit;
            nb  = 8'h0;
            hit = 1'b0;
            if (o == SB && k == int'(a[1:0])) begin hit = 1'b1; nb = wd[7:0]; end
            if (o == SH && k / 2 == int'(a[1])) begin hit = 1'b1; nb = wd[8*(k%2) +: 8]; end
            if (o == SW) begin hit = 1'b1; nb = wd[8*k +: 8]; end
            if (hit) w[8*k +: 8] = nb;
        end
        ref_mem[widx(a)] = w;
    endfunction

    task automatic set_idle();
        exp_stall = 1'b0; exp_rdata = 32'h0; exp_adel = 1'b0; exp_ades = 1'b0; lit_en = 1'b0;
    endtask

    // Issues one request on dut_a; starts and ends just after a rising edge.
    task automatic req_a(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd,
                         input logic use_lit, input logic [31:0] lit);
        logic ld, st, mis;
        ld  = (o == LB) || (o == LH) || (o == LW) || (o == LBU) || (o == LHU);
        st  = (o == SB) || (o == SH) || (o == SW);
        mis = ((o == LH || o == LHU || o == SH) && a[0]) ||
              ((o == LW || o == SW) && a[1:0] != 2'b00);
        memen_a = 1'b1; op_a = o; addr_a = a; wdata_a = wd;
        if (!(ld || st) || mis) begin
            set_idle();
            exp_adel = ld && mis;
            exp_ades = st && mis;
            @(posedge clk); #1;
        end else begin
            for (int c = 0; c <= W_A; c++) begin
                set_idle();
                exp_stall = 1'b1;
                @(posedge clk); #1;
                memen_a = 1'b0; op_a = 6'h0; addr_a = 32'h0; wdata_a = 32'h0;
            end
            set_idle();
            exp_rdata = ld ? model_load(o, a) : 32'h0;
            lit_en    = use_lit;
            exp_lit   = lit;
            @(posedge clk); #1;
            if (st) model_store(o, a, wd);
        end
        memen_a = 1'b0; op_a = 6'h0; addr_a = 32'h0; wdata_a = 32'h0;
        set_idle();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_stall", 32'(stall_a), 32'(exp_stall));
            chk("a_rdata", rdata_a, exp_rdata);
            chk("a_adel", 32'(adel_a), 32'(exp_adel));
            chk("a_ades", 32'(ades_a), 32'(exp_ades));
            if (lit_en) chk("a_rdata_literal", rdata_a, exp_lit);
        end
    end

    logic [5:0]  b_op   [9] = '{SW, SW, SW, SW, LW, LW, LW, LW, 6'h00};
    logic        b_en   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] b_addr [9] = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h40, 32'h40, 32'h44, 32'h44, 32'h0};
    logic [31:0] b_wd   [9] = '{32'hCAFEF00D, 32'hCAFEF00D, 32'h0BADC0DE, 32'h0BADC0DE,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        b_stl  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] b_rd   [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D,
                                32'h0, 32'h0BADC0DE, 32'h0};

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_stall", 32'(stall_a), 32'h0);
        chk("rst_a_rdata", rdata_a, 32'h0);
        chk("rst_a_adel", 32'(adel_a), 32'h0);
        chk("rst_a_ades", 32'(ades_a), 32'h0);
        chk("rst_b_stall", 32'(stall_b), 32'h0);
        chk("rst_b_rdata", rdata_b, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        set_idle();
        chk_en = 1'b1;

        req_a(SW,  32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        req_a(LW,  32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        req_a(LB,  32'h13, 32'h0, 1'b1, 32'hFFFFFFDE);
        req_a(LBU, 32'h13, 32'h0, 1'b1, 32'h000000DE);
        req_a(LH,  32'h10, 32'h0, 1'b1, 32'hFFFFBEEF);
        req_a(LHU, 32'h12, 32'h0, 1'b1, 32'h0000DEAD);

        req_a(SW,  32'h10, 32'hDEADBE08, 1'b0, 32'h0);
        req_a(SB,  32'h11, 32'h00000055, 1'b0, 32'h0);
        req_a(SH,  32'h12, 32'h00001234, 1'b0, 32'h0);
        req_a(LW,  32'h10, 32'h0, 1'b1, 32'h12345508);
        req_a(LB,  32'h11, 32'h0, 1'b1, 32'h00000055);
        req_a(LW,  32'h1010, 32'h0, 1'b1, 32'h12345508);

        req_a(SW,  32'h04, 32'hA5A5A5A5, 1'b0, 32'h0);
        req_a(LW,  32'h02, 32'h0, 1'b0, 32'h0);
        req_a(SH,  32'h05, 32'h0000FFFF, 1'b0, 32'h0);
        req_a(LW,  32'h04, 32'h0, 1'b1, 32'hA5A5A5A5);
        req_a(6'h00, 32'h04, 32'h0, 1'b0, 32'h0);

        // Reset pulse while a store sits in WAIT.
        req_a(SW,  32'h20, 32'h11223344, 1'b0, 32'h0);
        chk_en = 1'b0;
        memen_a = 1'b1; op_a = SW; addr_a = 32'h20; wdata_a = 32'hFFFFFFFF;
        @(posedge clk); #1;
        memen_a = 1'b0; op_a = 6'h0; addr_a = 32'h0; wdata_a = 32'h0;
        chk("wait_stall", 32'(stall_a), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rst_wait_stall", 32'(stall_a), 32'h0);
        chk("rst_wait_rdata", rdata_a, 32'h0);
        chk("rst_wait_adel", 32'(adel_a), 32'h0);
        @(negedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        set_idle();
        chk_en = 1'b1;
        req_a(LW,  32'h20, 32'h0, 1'b1, 32'h11223344);

        // Zero wait states with memen held across DONE.
        for (int c = 0; c < 9; c++) begin
            memen_b = b_en[c]; op_b = b_op[c]; addr_b = b_addr[c]; wdata_b = b_wd[c];
            #3;
            chk($sformatf("b_stall[%0d]", c), 32'(stall_b), 32'(b_stl[c]));
            chk($sformatf("b_rdata[%0d]", c), rdata_b, b_rd[c]);
            @(posedge clk); #1;
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the pipeline's memory-stage load/store requests. Accepts the MIPS opcode, byte address and store data; performs byte-lane steering and load extension; returns `rdata`.
- Holds the pipeline with `stall` for a fixed number of wait states.
- Contains the data RAM and flags misaligned accesses. Sits between the datapath memory stage and the write-back register.

Parameters:
- ADDR_WIDTH, 10, word-index bits; RAM depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra cycles spent in WAIT before the response (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- memen  in  1  request valid: a load/store is present in the memory stage.
- op  in  6  MIPS opcode of the request.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  extended load result; valid in the DONE cycle.
- stall  out  1  hold the pipeline; combinational.
- adel  out  1  load address error (misaligned load).
- ades  out  1  store address error (misaligned store).

Behaviour:
- Opcodes:
  - LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
  - Any other op with `memen`=1 is treated as no request: no stall, no write, `rdata`=0.
- Alignment:
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - Misaligned load: `adel`=1 combinationally while `memen`=1 and state IDLE. No stall, `rdata`=0, FSM stays IDLE.
  - Misaligned store: `ades`=1 under the same conditions. No stall, RAM unchanged, FSM stays IDLE.
- RAM index: addr[ADDR_WIDTH+1:2]; upper address bits are ignored (aliasing). RAM contents are not reset.
- FSM states: IDLE, WAIT, DONE.
  - IDLE + valid aligned request: `stall`=1 combinationally this cycle. The request (op, addr, wdata) is latched. Next state is WAIT if WAIT_CYCLES>0, else DONE. The wait counter loads WAIT_CYCLES-1.
  - WAIT: `stall`=1; the counter decrements. On counter==0, go to DONE.
  - DONE: `stall`=0; `rdata` is driven from the latched request. The pipeline advances on this edge. Next state is IDLE unconditionally; `memen` is ignored in DONE, so the same request is never re-accepted.
  - Back-to-back requests: the next request is accepted in the IDLE cycle following DONE.
  - Access latency = WAIT_CYCLES+1 stalled cycles plus 1 DONE cycle.
- Stores:
  - The RAM write is committed on the edge entering DONE, using byte enables:
    - SB: lane addr[1:0], data wdata[7:0] replicated.
    - SH: lanes {1,0} if addr[1]=0, else {3,2}.
    - SW: all lanes.
  - Unselected bytes are unchanged.
  - `rdata`=0 for stores.
- Loads:
  - The word is read at the latched index (synchronous read, captured on entry to DONE), so a load following a store to the same word returns the new data.
  - Extraction:
    - LB/LBU: byte at addr[1:0], sign/zero-extended.
    - LH/LHU: half at addr[1], sign/zero-extended.
    - LW: full word.
- Outputs outside DONE: `rdata`=0.
- Reset (asynchronous, rst=0): state IDLE, counter 0, latched request cleared, all outputs 0. Reset during WAIT aborts the access and no store is committed.
- `memen` deasserted mid-access (WAIT) is ignored; the latched request completes.

Decomposition:
- Shared package: opcode constants (OP_LB..OP_SW), FSM state encoding, helpers is_load/is_store/size.
- One sub-module, `dmem_lane_unit` (combinational): generates byte enables and lane-replicated write data for stores, and extracts/extends load data. The FSM, counter and RAM stay in the top level.

Test Plan:
- SW addr=0x10, wdata=0xDEADBEEF, WAIT_CYCLES=2 -> `stall` high 3 cycles, DONE on cycle 4; then LW 0x10 -> `rdata`=0xDEADBEEF in DONE.
- After word 0x10=0xDEADBEEF:
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x10 -> 0xFFFFBEEF.
  - LHU 0x12 -> 0x0000DEAD.
- SB 0x11 wdata=0x55, then SH 0x12 wdata=0x1234 -> LW 0x10 returns 0x12345508 (with word preloaded 0xDEADBE08 before the SB).
- LW 0x02 -> `adel`=1, `stall`=0, FSM IDLE; SH 0x05 -> `ades`=1 and word 0x04 unchanged when read back.
- Reset pulse (rst=0) during WAIT of an SW 0x20 wdata=0xFFFFFFFF -> outputs 0, FSM IDLE; subsequent LW 0x20 returns the prior contents.
- WAIT_CYCLES=0, `memen` held high with two consecutive LW -> pattern `stall` 1,0,1,0; each request is accepted once.
